// File: rtl/gated_pulse_counter.sv
// Gated detector-pulse counter for readout.
// Asynchronous detector edges are counted only inside readout gate windows.
// Counts accumulate over a programmed number of windows, and the total is
// presented through a valid/ack handshake.
module gated_pulse_counter #(
    parameter int CNT_W       = 24,
    parameter int REP_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic             gate_in,
    input  logic             arm,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] count,
    output logic [REP_W-1:0] gates_seen,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GATE = 2'd1,
        COUNT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] det_sync;
    logic [SYNC_STAGES-1:0] gate_sync;
    logic                   det_s;
    logic                   gate_s;
    logic                   det_s_d;
    logic                   gate_s_d;
    logic                   det_rise;
    logic                   gate_rise;
    logic                   gate_fall;
    logic [REP_W-1:0]       reps_lat;
    logic [REP_W-1:0]       gates_next;
    logic [CNT_W-1:0]       count_next;
    logic                   count_full;

    assign det_s      = det_sync[SYNC_STAGES-1];
    assign gate_s     = gate_sync[SYNC_STAGES-1];
    assign det_rise   = det_s & ~det_s_d;
    assign gate_rise  = gate_s & ~gate_s_d;
    assign gate_fall  = ~gate_s & gate_s_d;
    assign gates_next = gates_seen + {{(REP_W-1){1'b0}}, 1'b1};
    assign count_next = count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign count_full = &count;

    // Synchronizer chains for the asynchronous inputs plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            det_sync  <= '0;
            gate_sync <= '0;
            det_s_d   <= 1'b0;
            gate_s_d  <= 1'b0;
        end else begin
            det_sync  <= {det_sync[SYNC_STAGES-2:0], det_in};
            gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate_in};
            det_s_d   <= det_s;
            gate_s_d  <= gate_s;
        end
    end

    // Acquisition FSM: arm, wait for a fresh window, count inside it, then hold the result until acked
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            count        <= '0;
            gates_seen   <= '0;
            overflow     <= 1'b0;
            reps_lat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm && (reps != '0)) begin
                        reps_lat   <= reps;
                        count      <= '0;
                        gates_seen <= '0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= WAIT_GATE;
                    end
                end
                WAIT_GATE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gate_rise) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (det_rise && gate_s) begin
                            if (count_full) begin
                                overflow <= 1'b1;
                            end else begin
                                count <= count_next;
                            end
                        end
                        if (gate_fall) begin
                            gates_seen <= gates_next;
                            if (gates_next == reps_lat) begin
                                busy         <= 1'b0;
                                result_valid <= 1'b1;
                                state        <= DONE;
                            end else begin
                                state <= WAIT_GATE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (result_ack && result_valid) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Self-checking bench for gated_pulse_counter.
// A wide instance and a 4-bit-count instance share the same stimulus so the
// saturation behaviour can be observed alongside the normal results.
module tb_gated_pulse_counter;

    logic        clk;
    logic        reset;
    logic        det_in;
    logic        gate_in;
    logic        arm;
    logic [15:0] reps;
    logic        abort;
    logic        result_ack;

    logic        busy;
    logic        result_valid;
    logic [23:0] count;
    logic [15:0] gates_seen;
    logic        overflow;

    logic        n_busy;
    logic        n_valid;
    logic [3:0]  n_count;
    logic [15:0] n_gates;
    logic        n_ovf;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] reps;
        int          pre_pulses;
        int          p0;
        int          p1;
        int          p2;
        int          exp_count;
        int          exp_gates;
        int          exp_ncount;
        int          exp_novf;
    } vec_t;

    vec_t vecs[5];

    gated_pulse_counter #(.CNT_W(24), .REP_W(16), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .det_in(det_in), .gate_in(gate_in),
        .arm(arm), .reps(reps), .abort(abort), .busy(busy),
        .result_valid(result_valid), .result_ack(result_ack),
        .count(count), .gates_seen(gates_seen), .overflow(overflow)
    );

    gated_pulse_counter #(.CNT_W(4), .REP_W(16), .SYNC_STAGES(2)) u_narrow (
        .clk(clk), .reset(reset), .det_in(det_in), .gate_in(gate_in),
        .arm(arm), .reps(reps), .abort(abort), .busy(n_busy),
        .result_valid(n_valid), .result_ack(result_ack),
        .count(n_count), .gates_seen(n_gates), .overflow(n_ovf)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            det_in = 1'b1;
            repeat (4) tick();
            det_in = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic window(input int n);
        gate_in = 1'b1;
        repeat (2) tick();
        pulses(n);
        repeat (2) tick();
        gate_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic doArm(input logic [15:0] r);
        arm  = 1'b1;
        reps = r;
        tick();
        arm  = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int k;
        k = 0;
        while (!result_valid && k < 100) begin
            tick();
            k++;
        end
        checkOutput({name, "_valid"}, {31'd0, result_valid}, 32'd1);
        checkOutput({name, "_busy_at_valid"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic doAck();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    // One complete acquisition described by a table entry
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   n;
        v = vecs[idx];
        if (v.pre_pulses > 0) begin
            gate_in = 1'b1;
            repeat (4) tick();
        end
        doArm(v.reps);
        checkOutput($sformatf("v%0d_busy_after_arm", idx), {31'd0, busy}, 32'd1);
        checkOutput($sformatf("v%0d_count_cleared", idx), count, 32'd0);
        checkOutput($sformatf("v%0d_ncount_cleared", idx), {28'd0, n_count}, 32'd0);
        checkOutput($sformatf("v%0d_novf_cleared", idx), {31'd0, n_ovf}, 32'd0);
        if (v.pre_pulses > 0) begin
            pulses(v.pre_pulses);
            gate_in = 1'b0;
            repeat (4) tick();
        end
        for (int w = 0; w < int'(v.reps); w++) begin
            n = (w == 0) ? v.p0 : (w == 1) ? v.p1 : v.p2;
            pulses(1);
            window(n);
        end
        waitValid($sformatf("v%0d", idx));
        checkOutput($sformatf("v%0d_count", idx), count, v.exp_count);
        checkOutput($sformatf("v%0d_gates", idx), gates_seen, v.exp_gates);
        checkOutput($sformatf("v%0d_ovf", idx), {31'd0, overflow}, 32'd0);
        checkOutput($sformatf("v%0d_ncount", idx), {28'd0, n_count}, v.exp_ncount);
        checkOutput($sformatf("v%0d_novf", idx), {31'd0, n_ovf}, v.exp_novf);
        doAck();
        checkOutput($sformatf("v%0d_valid_cleared", idx), {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        det_in     = 1'b0;
        gate_in    = 1'b0;
        arm        = 1'b0;
        reps       = '0;
        abort      = 1'b0;
        result_ack = 1'b0;

        //           reps   pre p0 p1 p2 count gates ncount novf
        vecs[0] = '{16'd1, 0,  5, 0, 0,  5,   1,    5,    0};
        vecs[1] = '{16'd3, 0,  2, 0, 7,  9,   3,    9,    0};
        vecs[2] = '{16'd1, 3,  4, 0, 0,  4,   1,    4,    0};
        vecs[3] = '{16'd1, 0, 20, 0, 0, 20,   1,   15,    1};
        vecs[4] = '{16'd2, 0,  1, 3, 0,  4,   2,    4,    0};

        repeat (3) tick();
        reset = 1'b0;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_count", count, 32'd0);
        checkOutput("rst_gates", gates_seen, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(i);
            repeat (3) tick();
        end

        // Abort in the middle of a counting window keeps the partial count
        doArm(16'd2);
        gate_in = 1'b1;
        repeat (2) tick();
        pulses(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("abort_count", count, 32'd3);
        checkOutput("abort_gates", gates_seen, 32'd0);
        gate_in = 1'b0;
        repeat (10) tick();
        checkOutput("abort_valid_later", {31'd0, result_valid}, 32'd0);
        checkOutput("abort_gates_later", gates_seen, 32'd0);

        // Zero repetitions are refused
        doArm(16'd0);
        checkOutput("reps0_busy", {31'd0, busy}, 32'd0);
        window(2);
        checkOutput("reps0_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("reps0_count", count, 32'd3);

        // DONE ignores arm and abort until acked
        doArm(16'd1);
        pulses(1);
        window(2);
        waitValid("done");
        checkOutput("done_count", count, 32'd2);
        doArm(16'd5);
        checkOutput("done_arm_busy", {31'd0, busy}, 32'd0);
        checkOutput("done_arm_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("done_arm_count", count, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("done_abort_valid", {31'd0, result_valid}, 32'd1);
        doAck();
        checkOutput("ack_valid", {31'd0, result_valid}, 32'd0);
        doArm(16'd1);
        checkOutput("rearm_busy", {31'd0, busy}, 32'd1);
        checkOutput("rearm_count", count, 32'd0);
        pulses(1);
        window(1);
        waitValid("rearm");
        checkOutput("rearm_result", count, 32'd1);

        // Reset while a result is being presented
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_done_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done_count", count, 32'd0);
        checkOutput("rst_done_gates", gates_seen, 32'd0);
        checkOutput("rst_done_ovf", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
